time_of_day_counter: RTL and testbench

TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

---
 rtl/time_of_day_counter_pkg.sv | 21 ++
 rtl/time_of_day_counter_mod_counter.sv | 37 +++
 rtl/time_of_day_counter.sv | 84 ++++++++
 tb/tb_time_of_day_counter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/time_of_day_counter_pkg.sv
// Shared time-of-day constants and types, used by the counter, the day/night decoder
// and the traffic-light controller.
package time_of_day_counter_pkg;

    localparam int unsigned HOURS_PER_DAY    = 24;
    localparam int unsigned MINUTES_PER_HOUR = 60;
    localparam int unsigned HOUR_W           = 5;
    localparam int unsigned MIN_W            = 6;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
    } timeOfDay_t;

    // True when both fields lie inside a real clock face.
    function automatic logic isValidTime(input timeOfDay_t t);
        return (t.hours <= HOUR_W'(HOURS_PER_DAY - 1)) &&
               (t.minutes <= MIN_W'(MINUTES_PER_HOUR - 1));
    endfunction

endpackage

// File: rtl/time_of_day_counter_mod_counter.sv
// Modulo-N counter with clear/load/enable, a same-edge carry for chaining,
// and a registered wrap flag that is high while the wrapped value is shown.
module mod_counter #(
    parameter int unsigned MODULUS = 60,
    parameter int unsigned WIDTH   = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] loadVal,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             carry_c
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    assign carry_c = en & ~clr & ~ld & (count == MAX_VAL);

    // Priority: clear, then load, then counting; clear and load never flag a wrap.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (ld) begin
            count <= loadVal;
            wrap  <= 1'b0;
        end else begin
            wrap <= carry_c;
            if (en) begin
                count <= carry_c ? '0 : count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day clock: seconds prescaler -> minutes -> hours, with validated loads
// and hour/day strobes taken from the registered wrap flags.
module time_of_day_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int unsigned TICKS_PER_MIN = 60,
    parameter int unsigned RESET_HOUR    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_en,
    input  logic              load_valid,
    input  logic [HOUR_W-1:0] load_hours,
    input  logic [MIN_W-1:0]  load_minutes,
    output logic              load_ready,
    output logic              load_err,
    output logic [HOUR_W-1:0] hours_out,
    output logic [MIN_W-1:0]  minutes_out,
    output logic              hour_strobe,
    output logic              day_strobe
);

    localparam int unsigned SEC_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;

    timeOfDay_t        loadTime;
    logic              acceptLoad;
    logic              secEn;
    logic              secCarry;
    logic              minCarry;
    logic [HOUR_W-1:0] hourLoadVal;
    logic [SEC_W-1:0]  unusedSecCount;
    logic              unusedSecWrap;
    logic              unusedHourCarry;

    assign loadTime    = '{hours: load_hours, minutes: load_minutes};
    assign acceptLoad  = ~rst & load_valid & isValidTime(loadTime);
    // Any load attempt, valid or not, swallows a coincident tick.
    assign secEn       = tick_en & ~load_valid;
    assign hourLoadVal = rst ? HOUR_W'(RESET_HOUR) : load_hours;
    assign load_ready  = ~rst;

    mod_counter #(.MODULUS(TICKS_PER_MIN), .WIDTH(SEC_W)) secCounter (
        .clk     (clk),
        .clr     (rst | acceptLoad),
        .ld      (1'b0),
        .en      (secEn),
        .loadVal ('0),
        .count   (unusedSecCount),
        .wrap    (unusedSecWrap),
        .carry_c (secCarry)
    );

    mod_counter #(.MODULUS(MINUTES_PER_HOUR), .WIDTH(MIN_W)) minCounter (
        .clk     (clk),
        .clr     (rst),
        .ld      (acceptLoad),
        .en      (secCarry),
        .loadVal (load_minutes),
        .count   (minutes_out),
        .wrap    (hour_strobe),
        .carry_c (minCarry)
    );

    // Reset is a load of RESET_HOUR so the hour never passes through zero.
    mod_counter #(.MODULUS(HOURS_PER_DAY), .WIDTH(HOUR_W)) hourCounter (
        .clk     (clk),
        .clr     (1'b0),
        .ld      (rst | acceptLoad),
        .en      (minCarry),
        .loadVal (hourLoadVal),
        .count   (hours_out),
        .wrap    (day_strobe),
        .carry_c (unusedHourCarry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load_valid & ~isValidTime(loadTime);
        end
    end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: a minute-of-day reference model feeds
// expected outputs into a queue that a negedge monitor drains and compares.
module tb_time_of_day_counter;

    localparam int TPM = 2;
    localparam int RH  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_en = 1'b0;
    logic       load_valid = 1'b0;
    logic [4:0] load_hours = '0;
    logic [5:0] load_minutes = '0;
    logic       load_ready;
    logic       load_err;
    logic [4:0] hours_out;
    logic [5:0] minutes_out;
    logic       hour_strobe;
    logic       day_strobe;

    time_of_day_counter #(.TICKS_PER_MIN(TPM), .RESET_HOUR(RH)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .load_valid   (load_valid),
        .load_hours   (load_hours),
        .load_minutes (load_minutes),
        .load_ready   (load_ready),
        .load_err     (load_err),
        .hours_out    (hours_out),
        .minutes_out  (minutes_out),
        .hour_strobe  (hour_strobe),
        .day_strobe   (day_strobe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic       hs;
        logic       ds;
        logic       err;
    } exp_t;

    typedef struct {
        string name;
        int    got;
        int    want;
    } cnt_t;

    exp_t sbq[$];
    cnt_t cq[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   hsCount = 0;
    int   dsCount = 0;

    // Reference model state: minute of day and seconds into the current minute.
    int mTod = 0;
    int mSecs = 0;

    // Monitor: every cycle compare the DUT against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        cnt_t c;
        cycle++;
        if (hour_strobe === 1'b1) hsCount++;
        if (day_strobe === 1'b1) dsCount++;
        checks++;
        if (load_ready !== ~rst) begin
            errors++;
            $display("FAIL load_ready cycle %0d: got %b want %b", cycle, load_ready, ~rst);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            g = '{h: hours_out, m: minutes_out, hs: hour_strobe, ds: day_strobe, err: load_err};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sb cycle %0d: got %0d:%0d hs=%b ds=%b err=%b want %0d:%0d hs=%b ds=%b err=%b",
                         cycle, g.h, g.m, g.hs, g.ds, g.err, e.h, e.m, e.hs, e.ds, e.err);
            end
        end
        while (cq.size() != 0) begin
            c = cq.pop_front();
            checks++;
            if (c.got != c.want) begin
                errors++;
                $display("FAIL %s: got %0d want %0d", c.name, c.got, c.want);
            end
        end
    end

    // Drive one cycle of inputs, advance the model on the edge, queue the expectation.
    task automatic step(input logic r, input logic t, input logic lv, input int lh, input int lm);
        logic hs;
        logic ds;
        logic err;
        rst          = r;
        tick_en      = t;
        load_valid   = lv;
        load_hours   = 5'(lh);
        load_minutes = 6'(lm);
        @(posedge clk);
        hs = 1'b0;
        ds = 1'b0;
        err = 1'b0;
        if (r) begin
            mTod  = RH * 60;
            mSecs = 0;
        end else if (lv) begin
            if (lh < 24 && lm < 60) begin
                mTod  = lh * 60 + lm;
                mSecs = 0;
            end else begin
                err = 1'b1;
            end
        end else if (t) begin
            mSecs++;
            if (mSecs == TPM) begin
                mSecs = 0;
                mTod  = (mTod + 1) % 1440;
                hs    = (mTod % 60) == 0;
                ds    = mTod == 0;
            end
        end
        sbq.push_back('{h: 5'(mTod / 60), m: 6'(mTod % 60), hs: hs, ds: ds, err: err});
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hsStart;
        int dsStart;

        // Reset and release.
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 3, 3);
        idle(2);

        // 05:59 plus one minute of ticks crosses an hour.
        step(1'b0, 1'b0, 1'b1, 5, 59);
        ticks(TPM);
        idle(2);

        // 23:59 plus one minute wraps the day.
        step(1'b0, 1'b0, 1'b1, 23, 59);
        ticks(TPM);
        idle(2);

        // Load beats a coincident tick; seconds restart from zero.
        step(1'b0, 1'b1, 1'b1, 12, 30);
        ticks(TPM - 1);
        ticks(1);

        // Invalid loads leave the partial minute alone.
        ticks(1);
        step(1'b0, 1'b1, 1'b1, 24, 10);
        step(1'b0, 1'b1, 1'b1, 5, 60);
        step(1'b0, 1'b1, 1'b1, 31, 63);
        ticks(1);
        idle(1);

        // Reset mid-minute at 19:59, then a full day back to 06:00.
        step(1'b0, 1'b0, 1'b1, 19, 59);
        ticks(1);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        hsStart = hsCount;
        dsStart = dsCount;
        ticks(1440 * TPM);
        @(negedge clk);
        #1;
        cq.push_back('{name: "day_sweep_hour_strobes", got: hsCount - hsStart, want: 24});
        cq.push_back('{name: "day_sweep_day_strobes", got: dsCount - dsStart, want: 1});
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 200) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
                 int'($urandom % 32), int'($urandom % 64));
        end
        idle(3);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
